// File: rtl/mcpu5_run_sequencer.sv
// mcpu5_run_sequencer
// Host-side run controller for the MCPU5plus core. It holds a small program
// memory that is loaded over a valid/ready port. From the system clock it
// generates the core's two-phase clock and its reset. It feeds the core one
// instruction per core cycle, selected by the PC that the core drives on
// cpu_out during the high phase. OUT results are forwarded through a
// one-entry output register with backpressure. A HALT opcode or a stop
// request ends the run.
//
// Ports:
//   clk, rst                  system clock, asynchronous active-low reset
//   load_valid/ready/data     program load port (accepted in IDLE/HALTED)
//   start, stop               run control
//   cpu_clk, cpu_rst          generated core clock and active-high core reset
//   cpu_inst                  instruction bus to the core
//   cpu_out                   core output: PC when cpu_clk=1, accu when cpu_clk=0
//   out_valid/ready/data      OUT result stream
//   running, halted           run status
//   cycle_count               executed core edges since start, saturating
module mcpu5_run_sequencer #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [5:0]  load_data,
   input  logic        start,
   input  logic        stop,
   output logic        cpu_clk,
   output logic        cpu_rst,
   output logic [5:0]  cpu_inst,
   input  logic [7:0]  cpu_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        running,
   output logic        halted,
   output logic [15:0] cycle_count
);

   localparam int unsigned Depth  = 2 ** ADDR_W;
   localparam logic [5:0]  OpOut  = 6'h3B;
   localparam logic [5:0]  OpHalt = 6'h3A;

   typedef enum logic [2:0] {
      StIdle,
      StRstLo,
      StRstHi,
      StPhLo,
      StPhHi,
      StHalted
   } state_e;

   state_e            state;
   logic [ADDR_W-1:0] load_ptr;
   logic              stop_pend;
   logic [5:0]        mem [Depth];

   logic load_fire;
   logic out_stall;

   assign load_ready = (state == StIdle) || (state == StHalted);
   assign load_fire  = load_valid && load_ready;
   // An OUT cannot be pushed while the previous result is still held and not
   // being taken this cycle.
   assign out_stall  = (cpu_inst == OpOut) && out_valid && !out_ready;

   // Program memory keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         mem[load_ptr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         cpu_clk     <= 1'b0;
         cpu_rst     <= 1'b1;
         cpu_inst    <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         load_ptr    <= '0;
         cycle_count <= '0;
         running     <= 1'b0;
         halted      <= 1'b0;
         stop_pend   <= 1'b0;
      end else begin
         // A push in PH_LO below overrides this pop.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            StIdle, StHalted: begin
               if (load_fire) begin
                  load_ptr <= load_ptr + 1'b1;
               end
               if (start) begin
                  state       <= StRstLo;
                  load_ptr    <= '0;
                  cycle_count <= '0;
                  cpu_clk     <= 1'b0;
                  cpu_rst     <= 1'b1;
                  running     <= 1'b1;
                  halted      <= 1'b0;
                  stop_pend   <= 1'b0;
               end
            end

            StRstLo: begin
               if (stop) stop_pend <= 1'b1;
               state   <= StRstHi;
               cpu_clk <= 1'b1;
            end

            StRstHi: begin
               if (stop) stop_pend <= 1'b1;
               state    <= StPhLo;
               cpu_clk  <= 1'b0;
               cpu_rst  <= 1'b0;
               cpu_inst <= mem[0];
            end

            StPhLo: begin
               // HALT and stop both end the run before the pending
               // instruction sees a core edge.
               if ((cpu_inst == OpHalt) || stop || stop_pend) begin
                  state     <= StHalted;
                  running   <= 1'b0;
                  halted    <= 1'b1;
                  stop_pend <= 1'b0;
               end else if (!out_stall) begin
                  if (cpu_inst == OpOut) begin
                     out_data  <= cpu_out;
                     out_valid <= 1'b1;
                  end
                  state   <= StPhHi;
                  cpu_clk <= 1'b1;
                  if (cycle_count != 16'hFFFF) begin
                     cycle_count <= cycle_count + 16'd1;
                  end
               end
            end

            StPhHi: begin
               // A stop seen here is honoured at the end of the next PH_LO.
               if (stop) stop_pend <= 1'b1;
               state    <= StPhLo;
               cpu_clk  <= 1'b0;
               cpu_inst <= mem[cpu_out[ADDR_W-1:0]];
            end

            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu5_run_sequencer.sv
// Self-checking bench for mcpu5_run_sequencer. A small behavioural MCPU5
// core model drives cpu_out; a monitor collects every accepted OUT beat.
module tb_mcpu5_run_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [5:0]  load_data = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        cpu_clk;
   logic        cpu_rst;
   logic [5:0]  cpu_inst;
   logic [7:0]  cpu_out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        running;
   logic        halted;
   logic [15:0] cycle_count;

   int n_checks = 0;
   int n_pass   = 0;

   mcpu5_run_sequencer #(.ADDR_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .start       (start),
      .stop        (stop),
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .cpu_inst    (cpu_inst),
      .cpu_out     (cpu_out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .running     (running),
      .halted      (halted),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   // Minimal core model: LDI (01iiii), BCC with carry clear (00iiii, relative
   // to pc+1), everything else just advances the PC.
   logic [7:0] core_pc  = '0;
   logic [7:0] core_acc = '0;
   always @(posedge cpu_clk) begin
      if (cpu_rst) begin
         core_pc  <= '0;
         core_acc <= '0;
      end else begin
         case (cpu_inst[5:4])
            2'b01: begin
               core_acc <= {{4{cpu_inst[3]}}, cpu_inst[3:0]};
               core_pc  <= core_pc + 8'd1;
            end
            2'b00:   core_pc <= core_pc + 8'd1 + {{4{cpu_inst[3]}}, cpu_inst[3:0]};
            default: core_pc <= core_pc + 8'd1;
         endcase
      end
   end
   assign cpu_out = cpu_clk ? core_pc : core_acc;

   int unsigned tb_edges = 0;
   always @(posedge cpu_clk) begin
      if (!cpu_rst) tb_edges <= tb_edges + 1;
   end

   // Inputs change #1 after posedge, so negedge sees what the next edge sees.
   logic [7:0] rx_q[$];
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) rx_q.push_back(out_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [5:0] w);
      load_valid = 1'b1;
      load_data  = w;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic wait_halted(input string tag, input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         tick();
         n++;
      end
      check(tag, halted, 1);
   endtask

   int base;
   int unsigned e0;
   int n;

   initial begin
      repeat (3) tick();
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_cpu_clk", cpu_clk, 0);
      check("rst_cpu_inst", cpu_inst, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_running", running, 0);
      check("rst_halted", halted, 0);
      check("rst_cycles", cycle_count, 0);
      check("rst_load_ready", load_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Basic OUT/HALT
      load_word(6'h15); load_word(6'h3B); load_word(6'h3A);
      out_ready = 1'b1;
      base = rx_q.size();
      do_start();
      check("b_rstlo_rst", cpu_rst, 1);
      check("b_rstlo_clk", cpu_clk, 0);
      check("b_running", running, 1);
      check("b_load_ready_run", load_ready, 0);
      tick();
      check("b_rsthi_clk", cpu_clk, 1);
      check("b_rsthi_rst", cpu_rst, 1);
      tick();
      check("b_phlo_inst", cpu_inst, 6'h15);
      check("b_phlo_rst", cpu_rst, 0);
      check("b_phlo_clk", cpu_clk, 0);
      wait_halted("b_halted", 40);
      check("b_cycles", cycle_count, 2);
      check("b_cpu_clk", cpu_clk, 0);
      check("b_running_end", running, 0);
      check("b_beats", rx_q.size() - base, 1);
      check("b_data", rx_q[base], 8'h05);
      check("b_out_valid_end", out_valid, 0);

      // Backpressure
      out_ready = 1'b0;
      load_word(6'h11); load_word(6'h3B); load_word(6'h12); load_word(6'h3B);
      load_word(6'h3A);
      base = rx_q.size();
      do_start();
      repeat (20) tick();
      check("bp_stall_clk", cpu_clk, 0);
      check("bp_stall_inst", cpu_inst, 6'h3B);
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_data", out_data, 8'h01);
      check("bp_stall_cycles", cycle_count, 3);
      check("bp_stall_beats", rx_q.size() - base, 0);
      out_ready = 1'b1;
      wait_halted("bp_halted", 40);
      check("bp_beats", rx_q.size() - base, 2);
      check("bp_data0", rx_q[base], 8'h01);
      check("bp_data1", rx_q[base+1], 8'h02);
      check("bp_cycles", cycle_count, 4);
      check("bp_valid_end", out_valid, 0);

      // Stop during PH_LO
      load_word(6'h0F);
      e0 = tb_edges;
      do_start();
      repeat (12) tick();
      pulse_stop();
      check("st_halted_now", halted, 1);
      check("st_cycles", cycle_count, 5);
      check("st_edges", cycle_count, tb_edges - e0);
      check("st_inst", cpu_inst, 6'h0F);
      check("st_cpu_clk", cpu_clk, 0);
      pulse_stop();
      check("st_ignored_halted", halted, 1);
      check("st_ignored_cycles", cycle_count, 5);

      // Stop during PH_HI is deferred to the end of the next PH_LO
      do_start();
      repeat (11) tick();
      check("sh_in_phhi", cpu_clk, 1);
      pulse_stop();
      check("sh_not_yet", halted, 0);
      tick();
      check("sh_halted", halted, 1);
      check("sh_cycles", cycle_count, 5);

      // Load wrap: 65th word overwrites mem[0]
      for (int k = 0; k < 64; k++) load_word(6'(k));
      load_word(6'h15);
      do_start();
      tick();
      tick();
      check("lw_first_inst", cpu_inst, 6'h15);
      repeat (12) tick();
      pulse_stop();
      wait_halted("lw_halted", 10);

      // Async reset mid-run with an OUT result pending
      load_word(6'h15); load_word(6'h3B); load_word(6'h3A);
      out_ready = 1'b0;
      base = rx_q.size();
      do_start();
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("ar_pending", out_valid, 1);
      check("ar_in_phhi", cpu_clk, 1);
      #2 rst = 1'b0;
      #1;
      check("ar_cpu_clk", cpu_clk, 0);
      check("ar_cpu_rst", cpu_rst, 1);
      check("ar_out_valid", out_valid, 0);
      check("ar_running", running, 0);
      check("ar_cycles", cycle_count, 0);
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      do_start();
      wait_halted("ar_halted", 40);
      check("ar_beats", rx_q.size() - base, 1);
      check("ar_data", rx_q[base], 8'h05);
      check("ar_cycles_end", cycle_count, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mcpu5_run_sequencer.md
# mcpu5_run_sequencer

Host-side controller for the MCPU5plus core. It holds a small program memory that is loaded over a valid/ready port. It generates the core's two-phase clock and reset from one system clock, and feeds instructions by sampling the core's PC on its output bus. It detects OUT/HALT opcodes and forwards OUT results through a one-entry output register with backpressure.

## Interface
- ADDR_W, 6: program memory address width; depth 2^ADDR_W words of 6 bits.
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  program word offered.
- load_ready  out  1  high in IDLE and HALTED only.
- load_data  in  6  instruction word.
- start  in  1  begin run; sampled in IDLE/HALTED only.
- stop  in  1  request halt.
- cpu_clk  out  1  core clock.
- cpu_rst  out  1  core reset, active-high.
- cpu_inst  out  6  core instruction bus.
- cpu_out  in  8  core output: PC while cpu_clk=1, accu while cpu_clk=0.
- out_valid  out  1  out_data holds an unconsumed OUT result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  8  accu value at the OUT instruction.
- running  out  1  high from RST_LO until halt.
- halted  out  1  high in HALTED.
- cycle_count  out  16  core clock edges executed since start; saturates at 0xFFFF.

## Operation
- States: IDLE, RST_LO, RST_HI, PH_LO, PH_HI, HALTED.
- Loading happens in IDLE/HALTED. Each load_valid&&load_ready writes mem[load_ptr], then load_ptr increments modulo 2^ADDR_W.
- start (IDLE/HALTED) -> RST_LO:
  - load_ptr and cycle_count clear to 0; out_valid is not touched.
  - A load accepted in the same cycle is written first.
- RST_LO: cpu_clk=0, cpu_rst=1. Next state RST_HI.
- RST_HI: cpu_clk=1, cpu_rst=1; this core edge resets the core. Next state PH_LO with cpu_inst=mem[0] and cpu_rst=0.
- PH_LO: cpu_clk=0.
  - Captures cpu_out as accu_snap at end of phase.
  - cpu_inst=111011 (OUT): push accu_snap to out_data and set out_valid. If out_valid=1 and out_ready=0, stay in PH_LO (stall; cpu_clk held low).
  - cpu_inst=111010 (HALT): -> HALTED; that instruction is never clocked.
  - stop=1: -> HALTED.
  - Otherwise -> PH_HI; cycle_count+1.
- PH_HI: cpu_clk=1.
  - Captures cpu_out as the new PC.
  - Next state PH_LO with cpu_inst=mem[pc[ADDR_W-1:0]]; the PC wraps modulo depth.
- cpu_inst changes only on PH_HI->PH_LO and RST_HI->PH_LO. It is therefore stable across each core rising edge and throughout the low phase, when the core's STA writes occur.
- out_valid clears on out_valid&&out_ready unless a push happens in the same cycle; a simultaneous pop and push does not stall.
- HALTED: cpu_clk=0, cpu_rst=0, and the core state is frozen. out_valid/out_data continue to drain.
- stop while in IDLE/HALTED is ignored. start while running is ignored.
- Reset values: state IDLE, cpu_clk=0, cpu_rst=1, cpu_inst=0, out_valid=0, out_data=0, load_ptr=0, cycle_count=0, running=0, halted=0.
- Program memory is not reset.

## Timing
- One core instruction takes 2 clk cycles when there is no stall.
- start sampled at edge N:
  - RST_LO at N+1, RST_HI at N+2, PH_LO (mem[0]) at N+3.
  - The first instruction executes on the core edge at N+4.
- out_valid rises on the clk edge that ends the PH_LO phase of the OUT instruction.
- An asynchronous reset assertion mid-run forces the reset values immediately, regardless of phase. Release is synchronous to the next clk edge.
- stop asserted while in PH_HI takes effect at the end of the following PH_LO phase.

## Test plan
- Basic OUT/HALT:
  - Stimulus: load 0x15 (LDI 5), 0x3B (OUT), 0x3A (HALT); start; out_ready=1.
  - Response: exactly one out_valid beat with out_data=0x05, then halted=1, cycle_count=2, cpu_clk=0.
- Backpressure:
  - Stimulus: load LDI 1, OUT, LDI 2, OUT, HALT with out_ready=0; raise out_ready after 20 cycles.
  - Response: cpu_clk stays low at the second OUT; the consumer then receives 0x01 then 0x02; no loss or duplicate.
- Stop:
  - Stimulus: load 0x0F (BCC -1, a self-loop); start; pulse stop 12 cycles later.
  - Response: halted=1 at the next PH_LO exit; cycle_count equals the edges counted; cpu_inst=0x0F.
- Load wrap:
  - Stimulus: load 65 words, word k=k&0x3F, with the last word 0x15.
  - Response: mem[0]=0x15; the first cpu_inst after start is 0x15.
- Async reset mid-run:
  - Stimulus: assert rst low during PH_HI of scenario 1, then release.
  - Response: immediately cpu_clk=0, cpu_rst=1, out_valid=0, running=0. Restarting with start reproduces out_data=0x05 because memory is retained.
